// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and command record for the ALU command issuer.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_MUL    = 4'h4;
    localparam logic [3:0] OP_MOD3   = 4'h8;
    localparam logic [7:0] DUMMY_ANS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] num_1;
        logic [7:0] num_2;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; a push is refused while full even if a pop happens in the same cycle.
module alu_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only read while the count says it holds data.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, issues them to a one-cycle-latency ALU and returns each result over valid/ready.
// Define ALU_CMD_ISSUER_CHECK_EN to build the result self-check model driving rsp_mismatch.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int NUM_WIDTH  = 8,
    parameter int OP_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_WIDTH-1:0]  cmd_opcode,
    input  logic [NUM_WIDTH-1:0] cmd_num_1,
    input  logic [NUM_WIDTH-1:0] cmd_num_2,
    output logic [OP_WIDTH-1:0]  alu_opcode,
    output logic [NUM_WIDTH-1:0] alu_num_1,
    output logic [NUM_WIDTH-1:0] alu_num_2,
    input  logic [NUM_WIDTH-1:0] alu_ans,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NUM_WIDTH-1:0] rsp_ans,
    output logic [OP_WIDTH-1:0]  rsp_opcode,
    output logic                 rsp_err,
    output logic                 rsp_mismatch
);
    localparam int CMD_W = OP_WIDTH + 2 * NUM_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready
    // and payload stays stable while valid is high and ready is low.
    state_e               r_state;
    logic [OP_WIDTH-1:0]  r_alu_opcode;
    logic [NUM_WIDTH-1:0] r_alu_num_1;
    logic [NUM_WIDTH-1:0] r_alu_num_2;
    logic                 r_rsp_valid;
    logic [NUM_WIDTH-1:0] r_rsp_ans;
    logic [OP_WIDTH-1:0]  r_rsp_opcode;
    logic                 r_rsp_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_rsp_fire;
    logic [CMD_W-1:0]     w_head;
    logic [CNT_W-1:0]     w_unused_count;
    logic [OP_WIDTH-1:0]  w_head_opcode;
    logic [NUM_WIDTH-1:0] w_head_num_1;
    logic [NUM_WIDTH-1:0] w_head_num_2;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_pop   (w_pop),
        .i_wdata ({cmd_opcode, cmd_num_1, cmd_num_2}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_unused_count)
    );

    assign w_head_opcode = w_head[CMD_W-1 -: OP_WIDTH];
    assign w_head_num_1  = w_head[2*NUM_WIDTH-1 -: NUM_WIDTH];
    assign w_head_num_2  = w_head[NUM_WIDTH-1:0];

    assign w_rsp_fire = r_rsp_valid && rsp_ready;
    // The next command is taken either from idle or straight out of a completed response.
    assign w_pop = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && w_rsp_fire));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_alu_opcode <= '0;
            r_alu_num_1  <= '0;
            r_alu_num_2  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_ans    <= '0;
            r_rsp_opcode <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_alu_opcode <= w_head_opcode;
                        r_alu_num_1  <= w_head_num_1;
                        r_alu_num_2  <= w_head_num_2;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_rsp_ans    <= alu_ans;
                    r_rsp_opcode <= r_alu_opcode;
                    r_rsp_err    <= !$onehot(r_alu_opcode);
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                default: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_opcode <= w_head_opcode;
                            r_alu_num_1  <= w_head_num_1;
                            r_alu_num_2  <= w_head_num_2;
                            r_state      <= ST_ISSUE;
                        end else begin
                            r_alu_opcode <= '0;
                            r_alu_num_1  <= '0;
                            r_alu_num_2  <= '0;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ALU_CMD_ISSUER_CHECK_EN
    logic [NUM_WIDTH-1:0] w_exp_ans;
    logic                 r_mismatch;

    always_comb begin
        w_exp_ans = NUM_WIDTH'(DUMMY_ANS);
        case (r_alu_opcode)
            OP_WIDTH'(OP_ADD):  w_exp_ans = r_alu_num_1 + r_alu_num_2;
            OP_WIDTH'(OP_SUB):  w_exp_ans = r_alu_num_1 - r_alu_num_2;
            OP_WIDTH'(OP_MUL):  w_exp_ans = NUM_WIDTH'(r_alu_num_1[3:0]) * NUM_WIDTH'(r_alu_num_2[3:0]);
            OP_WIDTH'(OP_MOD3): w_exp_ans = r_alu_num_1 % NUM_WIDTH'(3);
            default:            w_exp_ans = NUM_WIDTH'(DUMMY_ANS);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_mismatch <= (w_exp_ans != alu_ans);
        end
    end

    assign rsp_mismatch = r_mismatch && r_rsp_valid;
`else
    assign rsp_mismatch = 1'b0;
`endif

    assign cmd_ready  = !w_full;
    assign alu_opcode = r_alu_opcode;
    assign alu_num_1  = r_alu_num_1;
    assign alu_num_2  = r_alu_num_2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_ans    = r_rsp_ans;
    assign rsp_opcode = r_rsp_opcode;
    assign rsp_err    = r_rsp_err;

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU opcode/operand interface.
- Accepts operation commands from a controller over a valid/ready handshake and buffers them in a small FIFO.
- Drives opcode/num_1/num_2 into the registered ALU, captures its one-cycle-latency ans, and returns the result with a valid/ready handshake.
- Sits between the control/test logic and the ALU datapath.

Parameters:
- NUM_WIDTH, 8, operand and result width.
- OP_WIDTH, 4, opcode width (one-hot legal opcodes).
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_opcode  input  OP_WIDTH  requested operation.
- cmd_num_1  input  NUM_WIDTH  first operand.
- cmd_num_2  input  NUM_WIDTH  second operand.
- alu_opcode  output  OP_WIDTH  opcode driven to ALU.
- alu_num_1  output  NUM_WIDTH  operand 1 driven to ALU.
- alu_num_2  output  NUM_WIDTH  operand 2 driven to ALU.
- alu_ans  input  NUM_WIDTH  registered ALU result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_ans  output  NUM_WIDTH  captured result.
- rsp_opcode  output  OP_WIDTH  opcode that produced rsp_ans.
- rsp_err  output  1  opcode was not one of 4'h1/4'h2/4'h4/4'h8.
- rsp_mismatch  output  1  self-check failure (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, except cmd_ready=1. FIFO emptied, FSM to IDLE.
- Reset mid-operation: in-flight command and queued commands are discarded; no response is produced for them.
- Command push: occurs on a cycle where cmd_valid && cmd_ready.
  - cmd_ready = !fifo_full. A push is not allowed while full, even when a pop occurs in the same cycle.
  - Pop and push in the same cycle on a non-full FIFO are both performed; the occupancy count is unchanged.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: alu_opcode=0. If the FIFO is non-empty, pop the head into the alu_* registers and go to ISSUE.
  - ISSUE: alu_* held stable; the ALU registers its result at the closing edge. Go to CAPTURE.
  - CAPTURE: latch alu_ans into rsp_ans and alu_opcode into rsp_opcode. Set rsp_valid=1 and rsp_err=(opcode not in {1,2,4,8}). Go to RESP.
  - RESP: hold all rsp_* stable while !rsp_ready. On rsp_valid && rsp_ready:
    - clear rsp_valid;
    - if the FIFO is non-empty, pop directly and go to ISSUE; otherwise go to IDLE.
- alu_* outputs hold their last value outside IDLE; they are cleared to 0 on entering IDLE.
- Latency: a command accepted at edge e0 into an empty FIFO with an idle FSM raises rsp_valid after edge e3.
- Throughput: one result per 3 cycles with rsp_ready tied high.
- Illegal opcodes are still issued to the ALU. The ALU returns 8'hFF, which is passed through with rsp_err=1.
- Width: rsp_ans is passed through unmodified; no widening or saturation.
- Capacity: at most FIFO_DEPTH + 1 commands are outstanding (FIFO plus engine).

Optional Feature:
- Macro: ALU_CMD_ISSUER_CHECK_EN.
- With the macro: an internal model computes the expected result at CAPTURE, truncated to NUM_WIDTH.
  - 4'h1: num_1+num_2.
  - 4'h2: num_1-num_2.
  - 4'h4: num_1[3:0]*num_2[3:0].
  - 4'h8: num_1 mod 3.
  - Otherwise: 8'hFF.
  - rsp_mismatch = (expected != alu_ans), registered alongside rsp_ans and valid only with rsp_valid.
- Without the macro: rsp_mismatch is tied to 0 and no model logic exists.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD=4'h1, OP_SUB=4'h2, OP_MUL=4'h4, OP_MOD3=4'h8;
  - DUMMY_ANS=8'hFF;
  - FSM state enum;
  - command struct {opcode, num_1, num_2}.
- Sub-module alu_cmd_fifo: synchronous FIFO with push/pop/full/empty/count, reset-cleared pointers.

Test Plan:
- Add: opcode 4'h1, 8'h0F, 8'h01 -> rsp_ans=8'h10, rsp_err=0, rsp_valid rises 3 cycles after accept.
- Sub with wrap: opcode 4'h2, 8'h05, 8'h07 -> rsp_ans=8'hFE. Mul with nibble truncation: opcode 4'h4, 8'h3F, 8'h25 -> 8'h4B.
- Mod3 and illegal opcode: opcode 4'h8, num_1=8'd200 -> 8'h02. Opcode 4'h3 -> rsp_ans=8'hFF, rsp_err=1.
- Backpressure: rsp_ready=0, offer 7 back-to-back commands -> 5 accepted (1 engine + 4 FIFO), cmd_ready=0 from the 6th. After releasing rsp_ready, all 5 responses return in order and unchanged while stalled.
- Reset mid-operation: assert rst for 1 cycle while in ISSUE with 3 queued -> rsp_valid=0, cmd_ready=1, alu_opcode=0, no further responses.
- Check macro: with ALU_CMD_ISSUER_CHECK_EN and an ALU stub forcing alu_ans=8'h00 on an add of 8'h01+8'h01 -> rsp_mismatch=1. Without the macro -> rsp_mismatch=0.
